// File: rtl/handshake_master_arbiter_pkg.sv
// Shared encodings for the handshake master arbiter and slave controller.
// State codes and default payload width live here.
package handshake_master_arbiter_pkg;

  localparam int DATA_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    SEND  = 2'b10,
    ABORT = 2'b11
  } state_t;

endpackage

// File: rtl/handshake_master_arbiter_rr.sv
// Round-robin grant selector with its own last-grant pointer.
// Search starts one past the pointer so the last winner ranks lowest.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 gnt_en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW:0]   sum;
  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N))
        sum = sum - (PW+1)'(N);
      cand = sum[PW-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        idx       = cand;
        gnt       = '0;
        gnt[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= PW'(N-1);
    else if (gnt_en)
      ptr <= idx;
  end

endmodule

// File: rtl/handshake_master_arbiter.sv
// Shares one handshake slave among N masters, round-robin,
// running request/ack/valid/ack on the granted master's behalf.
module handshake_master_arbiter
  import handshake_master_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = DATA_W,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] m_req,
  input  logic [N*W-1:0] m_data,
  output logic [N-1:0] m_gnt,
  output logic [N-1:0] m_done,
  output logic [N-1:0] m_err,
  output logic         request,
  input  logic         ack,
  input  logic         notice,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         busy
);

  localparam int PW = $clog2(N);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT-1);

  state_t        state, state_d;
  logic [TW-1:0] cnt, cnt_d;
  logic          ack_d, ack_rise;

  logic [N-1:0]  gnt_d, done_d, err_d;
  logic          req_d, valid_d, busy_d;
  logic [W-1:0]  data_d;

  logic [N-1:0]  arb_gnt;
  logic [PW-1:0] arb_idx;
  logic          gnt_en;

  logic          unused_notice;
  assign unused_notice = notice;

  assign ack_rise = ack & ~ack_d;

  rr_arbiter #(.N(N)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (m_req),
    .gnt_en (gnt_en),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    gnt_d   = m_gnt;
    done_d  = '0;
    err_d   = '0;
    req_d   = request;
    valid_d = valid;
    data_d  = data;
    gnt_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|m_req) begin
          gnt_en  = 1'b1;
          gnt_d   = arb_gnt;
          data_d  = m_data[int'(arb_idx)*W +: W];
          req_d   = 1'b1;
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (ack) begin
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = SEND;
          cnt_d   = '0;
        end else if (cnt == LAST) begin
          req_d   = 1'b0;
          err_d   = m_gnt;
          gnt_d   = '0;
          state_d = ABORT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + TW'(1);
        end
      end
      SEND: begin
        // entry ack may still be the first-phase one; only a fresh edge completes
        if (ack_rise) begin
          valid_d = 1'b0;
          done_d  = m_gnt;
          gnt_d   = '0;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == LAST) begin
          valid_d = 1'b0;
          err_d   = m_gnt;
          gnt_d   = '0;
          state_d = ABORT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + TW'(1);
        end
      end
      ABORT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) | (|done_d) | (|err_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ack_d   <= 1'b0;
      m_gnt   <= '0;
      m_done  <= '0;
      m_err   <= '0;
      request <= 1'b0;
      valid   <= 1'b0;
      data    <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      ack_d   <= ack;
      m_gnt   <= gnt_d;
      m_done  <= done_d;
      m_err   <= err_d;
      request <= req_d;
      valid   <= valid_d;
      data    <= data_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: doc/handshake_master_arbiter.md
Name: handshake_master_arbiter

Overview:
- Shares one handshake slave (request/ack/notice/valid/data protocol, 3-bit payload) between N requesting masters.
- Grants one master at a time, round-robin.
- Runs the full master-side handshake on that master's behalf: request, wait for ack, present data with valid, wait for the completion ack.
- Reports done or timeout-error back to the granted master.
- Sits between the producer blocks and the slave controller, as the single driver of the slave's request/valid/data inputs.

Parameters:
- N, 4, number of masters (2..8).
- W, 3, payload width; must match the slave data width.
- TIMEOUT, 64, max cycles spent in REQ or in SEND before abort (>=4).
- TW, 7, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- m_req  in  N  per-master transfer request; level, held until m_done or m_err.
- m_data  in  N*W  per-master payload; master i occupies bits [i*W +: W].
- m_gnt  out  N  one-hot grant; held from grant until transfer end.
- m_done  out  N  one-cycle pulse to the granted master on successful transfer.
- m_err  out  N  one-cycle pulse to the granted master on timeout.
- request  out  1  to slave.
- ack  in  1  from slave.
- notice  in  1  from slave; observed only, no control effect.
- valid  out  1  to slave.
- data  out  W  to slave.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered. On reset: state=IDLE, m_gnt=0, m_done=0, m_err=0, request=0, valid=0, data=0, busy=0, rr pointer=N-1, timeout count=0, ack_d=0.
- Reset mid-transfer drops everything to the reset values in one cycle, with no done or err pulse.
- ack_d is ack registered one cycle. ack_rise = ack & ~ack_d.
- IDLE:
  - If any m_req is high, the arbiter picks the first requester strictly after the pointer, wrapping modulo N.
  - Next cycle: m_gnt=onehot(g), pointer=g, data register loads the m_data slice g, request=1, state=REQ, count=0.
  - Latency from m_req to request: 1 cycle.
- REQ:
  - request=1 is held.
  - On ack=1: request=0, valid=1, state=SEND, count=0.
  - Otherwise count increments. When count reaches TIMEOUT-1, go to ABORT.
- SEND:
  - valid=1 and data are held stable.
  - The slave's first-phase ack may still be high on entry. Completion is therefore ack_rise only.
  - On ack_rise: valid=0, m_done[g]=1 for one cycle, m_gnt=0, state=IDLE.
  - Count and timeout work as in REQ.
- ABORT (1 cycle): request=0, valid=0, m_err[g]=1 pulse, m_gnt=0, then IDLE.
- Ack while IDLE is ignored.
- m_req dropping while granted is ignored; the transfer completes.
- The data register is loaded only at grant, so m_data changes after grant have no effect.
- Back-to-back transfers: the earliest next grant is the cycle after done/err, giving at least one IDLE cycle with request=0 between transfers.
- Round-robin: a master just served has lowest priority next. With all N requesting continuously, grants cycle 0,1,..,N-1,0.
- Simultaneous requests in IDLE are resolved by the pointer only; there is no fixed priority.
- m_done and m_err are mutually exclusive and are never asserted together with busy=0 in the same cycle they fire. They fire on the transition edge; busy drops the following cycle.

Decomposition:
- Shared package: state encoding constants (IDLE=2'b00, REQ=2'b01, SEND=2'b10, ABORT=2'b11) and the default W=3 payload width constant, shared with the slave controller.
- One sub-module, rr_arbiter:
  - Combinational next-grant one-hot from req[N-1:0] and a registered pointer input.
  - Owns the pointer register, updated on a grant-enable strobe.
- The top level holds the FSM, timeout counter, data register and ack_d.

Test Plan:
- Single master: m_req[2]=1, m_data slice=3'b101; slave acks after 5 cycles. Required: m_gnt=4'b0100 and request=1 one cycle later. valid=1 with data=3'b101 the cycle after ack. m_done[2] pulses one cycle after the second ack rise. busy low afterwards.
- All four masters request continuously for 8 transfers. Required: grant order 0,1,2,3,0,1,2,3, with exactly one m_done per grant and request low for at least 1 cycle between transfers.
- Slave never acks. Required: request high for exactly TIMEOUT=64 cycles, then m_err[g] pulses once, request=0, state IDLE. A subsequent transfer succeeds.
- Slave acks REQ and then never gives the second ack. Required: valid held with stable data for 64 cycles, then m_err pulse and valid=0.
- First-phase ack held high 2 cycles into SEND, then low, then high. Required: m_done only on the later rising edge, not on entry.
- rst=1 asserted in SEND. Required: next cycle all outputs 0, no m_done/m_err. After release, a pending m_req[0] gets a grant first (pointer=N-1).
